vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//   Parametrised VGA timing and test-pattern generator; successor to the fixed 640x480, 1-bit-colour vga core.
//   Derives a pixel-enable tick from CLOCK_50 and runs the H/V counters and sync generation.
//   Provides four runtime-selectable patterns at COLOR_W bits per channel.
//   Drives the GPIO VGA pins directly from the top level.
// PARAMETERS
//   COLOR_W   4    bits per colour channel (1..8)
//   CLK_DIV   2    CLOCK_50 cycles per pixel (2 -> 25 MHz pixel rate); CLK_DIV>=1
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   hsync width (pixels)
//   H_BP      48   horizontal back porch (pixels)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vsync width (lines)
//   V_BP      33   vertical back porch (lines)
//   SYNC_POL  0    asserted sync level (0 = active-low)
//   CHK_LOG2  5    checkerboard square size = 2**CHK_LOG2 pixels
//   BOX_SIZE  32   side of the bouncing box (pixels)
// PORTS
//   CLOCK_50       in   1        system clock; the only clock
//   i_rst_n        in   1        asynchronous active-low reset
//   i_sel          in   2        pattern: 0 bars, 1 checker, 2 bouncing box, 3 solid
//   i_rgb          in   3*COLOR_W  solid colour {r,g,b} for mode 3
//   o_hsync        out  1        horizontal sync, polarity per SYNC_POL
//   o_vsync        out  1        vertical sync, polarity per SYNC_POL
//   o_red          out  COLOR_W  red channel
//   o_grn          out  COLOR_W  green channel
//   o_blu          out  COLOR_W  blue channel
//   o_de           out  1        display enable (active-video pixel)
//   o_frame_start  out  1        1-CLOCK_50 pulse on the tick where h=0, v=0
// BEHAVIOUR
//   Reset: all counters 0; o_hsync/o_vsync = ~SYNC_POL; colours 0; o_de 0; o_frame_start 0; box at (0,0) moving +x,+y; mode 0.
//   Tick: div counter runs 0..CLK_DIV-1; tick=1 when div==CLK_DIV-1 (tick every cycle if CLK_DIV=1).
//     All state except div advances only on tick.
//   H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//     h wraps at H_TOTAL-1 -> 0; v increments on h wrap and wraps at V_TOTAL-1 -> 0.
//   Registered outputs, updated on tick; they reflect the (h,v) value present before the tick: one pixel of latency.
//   hsync asserted while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//   vsync asserted while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
//   de = (h<H_ACTIVE)&&(v<V_ACTIVE); when de=0, all colour outputs = 0.
//   Mode latch: i_sel and i_rgb are sampled only on the frame-start tick; changes mid-frame take effect on the next frame.
//   Mode 0: 8 vertical bars, idx = h/(H_ACTIVE/8), clamped to 7. Channel = {COLOR_W{idx[2]}} red, idx[1] green, idx[0] blue.
//   Mode 1: white if ((h>>CHK_LOG2)^(v>>CHK_LOG2))[0], else black.
//   Mode 2: white inside [bx,bx+BOX_SIZE) x [by,by+BOX_SIZE); blue (all ones) elsewhere.
//     On each frame-start tick, bx += dx, by += dy (step 1).
//     The step direction reverses when the next position would leave 0..H_ACTIVE-BOX_SIZE (or V_ACTIVE-BOX_SIZE), so the box never clips.
//     At the corner, both directions reverse in the same frame.
//   Mode 3: latched i_rgb split {r,g,b}.
//   Counter widths = $clog2(TOTAL); no overflow beyond TOTAL-1.
//   Reset asserted mid-frame: immediate return to reset values; the first tick after release starts at h=0, v=0 and
//     asserts o_frame_start.
// TESTING
//   1. Small timing (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2) -> hsync low exactly 4 CLOCK_50 cycles per 28-cycle line;
//      vsync low for 1 line; frame = 196 cycles.
//   2. Mode 0, default timing -> h=0..79 gives 000; h=80 gives 001 (blue 4'hF); h=560..639 gives 4'hF on all channels;
//      h>=640 gives 0 and de=0.
//   3. Switch i_sel 0->3 with i_rgb=12'hA5C at mid-frame -> colours are unchanged until the next o_frame_start;
//      then active pixels = A,5,C.
//   4. Mode 2, H_ACTIVE=64, BOX_SIZE=32 -> bx counts 0..32 and back to 0; it never exceeds 32;
//      the reversal frame has bx=32 followed by 31.
//   5. Pulse i_rst_n low mid-line for 3 cycles -> outputs immediately go to their reset levels;
//      o_frame_start fires on the first tick after release.
//   6. CLK_DIV=1, COLOR_W=8 -> tick every cycle; mode 1, CHK_LOG2=5: pixel (32,0) is white and (32,32) is black.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing and 4-pattern generator; CLOCK_50/i_rst_n in, i_sel/i_rgb pick the pattern, sync/de/frame_start/rgb out
module vga_pattern_gen #(
  parameter int COLOR_W  = 4,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CHK_LOG2 = 5,
  parameter int BOX_SIZE = 32
) (
  input  logic                   CLOCK_50,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_sel,
  input  logic [3*COLOR_W-1:0]   i_rgb,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [COLOR_W-1:0]     o_red,
  output logic [COLOR_W-1:0]     o_grn,
  output logic [COLOR_W-1:0]     o_blu,
  output logic                   o_de,
  output logic                   o_frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] H_END  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_S0   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_S1   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_A    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] BAR_W  = HW'(H_ACTIVE / 8);
  localparam logic [HW-1:0] BX_MAX = HW'(H_ACTIVE - BOX_SIZE);
  localparam logic [HW-1:0] BOX_H  = HW'(BOX_SIZE);
  localparam logic [VW-1:0] V_END  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_S0   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_S1   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_A    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] BY_MAX = VW'(V_ACTIVE - BOX_SIZE);
  localparam logic [VW-1:0] BOX_V  = VW'(BOX_SIZE);
  logic [DW-1:0] div;
  logic [HW-1:0] h, bx, bx_s, bx_e, bar;
  logic [VW-1:0] v, by, by_s, by_e;
  logic dx, dy, dx_s, dy_s, tick, fs, de, hs, vs, chk, in_box;
  logic [1:0] sel_q, sel_e;
  logic [2:0] idx;
  logic [3*COLOR_W-1:0] rgb_q, rgb_e, bars, col;
  always_comb begin
    tick = div == DW'(CLK_DIV - 1);
    fs = tick && h == '0 && v == '0;
    hs = h >= H_S0 && h < H_S1;
    vs = v >= V_S0 && v < V_S1;
    de = h < H_A && v < V_A;
    // dx/dy = 1 means moving toward larger coordinates; reverse instead of stepping past an edge
    bx_s = dx ? (bx == BX_MAX ? bx - HW'(1) : bx + HW'(1)) : (bx == '0 ? bx + HW'(1) : bx - HW'(1));
    dx_s = dx ? bx != BX_MAX : bx == '0;
    by_s = dy ? (by == BY_MAX ? by - VW'(1) : by + VW'(1)) : (by == '0 ? by + VW'(1) : by - VW'(1));
    dy_s = dy ? by != BY_MAX : by == '0;
    // on the frame-start tick the freshly latched settings already apply to pixel (0,0)
    sel_e = fs ? i_sel : sel_q;
    rgb_e = fs ? i_rgb : rgb_q;
    bx_e = fs ? bx_s : bx;
    by_e = fs ? by_s : by;
    bar = h / BAR_W;
    idx = bar > HW'(7) ? 3'd7 : 3'(bar);
    chk = (((h >> CHK_LOG2) ^ HW'(v >> CHK_LOG2)) & HW'(1)) != '0;
    in_box = h >= bx_e && h < bx_e + BOX_H && v >= by_e && v < by_e + BOX_V;
    bars = {{COLOR_W{idx[2]}}, {COLOR_W{idx[1]}}, {COLOR_W{idx[0]}}};
    col = !de ? '0 : sel_e == 2'd0 ? bars : sel_e == 2'd1 ? {3*COLOR_W{chk}} :
          sel_e == 2'd2 ? (in_box ? {3*COLOR_W{1'b1}} : {{2*COLOR_W{1'b0}}, {COLOR_W{1'b1}}}) : rgb_e;
  end
  always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div <= '0;
      h <= '0;
      v <= '0;
      o_hsync <= ~SYNC_POL;
      o_vsync <= ~SYNC_POL;
      o_de <= 1'b0;
      o_frame_start <= 1'b0;
      {o_red, o_grn, o_blu} <= '0;
      sel_q <= 2'd0;
      rgb_q <= '0;
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      o_frame_start <= fs;
      if (tick) begin
        h <= h == H_END ? '0 : h + HW'(1);
        if (h == H_END) v <= v == V_END ? '0 : v + VW'(1);
        o_hsync <= hs ? SYNC_POL : ~SYNC_POL;
        o_vsync <= vs ? SYNC_POL : ~SYNC_POL;
        o_de <= de;
        {o_red, o_grn, o_blu} <= col;
        if (fs) begin
          sel_q <= i_sel;
          rgb_q <= i_rgb;
          bx <= bx_s;
          by <= by_s;
          dx <= dx_s;
          dy <= dy_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: three configurations checked every cycle against a closed-form pixel/frame model
module tb_vga_pattern_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [3];
  logic [1:0] sel [3];
  logic [23:0] rgb [3];
  int n_chk = 0;
  int n_fail = 0;
  int rcnt = 0;
  function automatic int tri_pos(input int k, input int m);
    int t;
    t = k % (2 * m);
    return t <= m ? t : 2 * m - t;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int CW  = g == 2 ? 8 : 4;
    localparam int DIV = g == 2 ? 1 : 2;
    localparam int HA  = g == 0 ? 640 : g == 1 ? 8 : 64;
    localparam int HF  = g == 0 ? 16 : g == 1 ? 2 : 1;
    localparam int HS  = g == 0 ? 96 : g == 1 ? 2 : 1;
    localparam int HB  = g == 0 ? 48 : g == 1 ? 2 : 1;
    localparam int VA  = g == 0 ? 8 : g == 1 ? 4 : 33;
    localparam int VF  = 1;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam bit POL = g == 2;
    localparam int CHK = g == 1 ? 1 : 5;
    localparam int BOX = g == 0 ? 4 : g == 1 ? 2 : 32;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FT  = HT * VT;
    logic hs, vs, de, fs;
    logic [CW-1:0] r, gr, b;
    int e;
    logic [1:0] msel;
    logic [3*CW-1:0] mrgb;
    vga_pattern_gen #(.COLOR_W(CW), .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL),
                      .CHK_LOG2(CHK), .BOX_SIZE(BOX)) dut (
      .CLOCK_50(clk), .i_rst_n(rst_n[g]), .i_sel(sel[g]), .i_rgb(rgb[g][3*CW-1:0]),
      .o_hsync(hs), .o_vsync(vs), .o_red(r), .o_grn(gr), .o_blu(b), .o_de(de), .o_frame_start(fs));
    always @(posedge clk) begin
      if (!rst_n[g]) begin
        e <= 0;
        msel <= 2'd0;
        mrgb <= '0;
      end else begin
        e <= e + 1;
        if ((e + 1) % DIV == 0 && ((e + 1) / DIV - 1) % FT == 0) begin
          msel <= sel[g];
          mrgb <= rgb[g][3*CW-1:0];
        end
      end
    end
    always @(negedge clk) begin : chk
      int p, pf, k, h, v, idx, bx, by;
      logic [3:0] es;
      logic [3*CW-1:0] ec;
      if (!rst_n[g] || e < DIV) begin
        es = {!POL, !POL, 2'b00};
        ec = '0;
      end else begin
        p = e / DIV - 1;
        pf = p % FT;
        k = p / FT + 1;
        h = pf % HT;
        v = pf / HT;
        es[3] = (h >= HA + HF && h < HA + HF + HS) ? POL : !POL;
        es[2] = (v >= VA + VF && v < VA + VF + VS) ? POL : !POL;
        es[1] = h < HA && v < VA;
        es[0] = e % DIV == 0 && pf == 0;
        idx = h / (HA / 8);
        if (idx > 7) idx = 7;
        bx = tri_pos(k, HA - BOX);
        by = tri_pos(k, VA - BOX);
        if (!es[1]) ec = '0;
        else case (msel)
          2'd0: ec = {{CW{idx[2]}}, {CW{idx[1]}}, {CW{idx[0]}}};
          2'd1: ec = (((h >> CHK) ^ (v >> CHK)) & 1) != 0 ? {3*CW{1'b1}} : '0;
          2'd2: ec = (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? {3*CW{1'b1}} : {{2*CW{1'b0}}, {CW{1'b1}}};
          default: ec = mrgb;
        endcase
      end
      n_chk++;
      assert ({hs, vs, de, fs} === es) else begin
        n_fail++;
        $error("FAIL u%0d timing e=%0d: got hs/vs/de/fs=%b want %b", g, e, {hs, vs, de, fs}, es);
      end
      n_chk++;
      assert ({r, gr, b} === ec) else begin
        n_fail++;
        $error("FAIL u%0d colour e=%0d mode=%0d: got %h want %h", g, e, msel, {r, gr, b}, ec);
      end
    end
  end
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) rst_n[1] = 1'b1;
      end else if ($urandom_range(0, 3000) == 0) begin
        rst_n[1] = 1'b0;
        rcnt = 3;
      end
      if ($urandom_range(0, 150) == 0) begin
        sel[1] = 2'($urandom);
        rgb[1] = 24'($urandom);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      rgb[i] = 24'($urandom);
    end
    sel[0] = 2'd0;
    sel[1] = 2'($urandom);
    sel[2] = 2'd1;
    run(3);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    run(8000);
    sel[0] = 2'd3;
    rgb[0] = 24'hA5C;
    sel[2] = 2'd2;
    run(12000);
    sel[0] = 2'($urandom);
    rgb[0] = 24'($urandom);
    run(6000);
    rst_n[0] = 1'b0;
    run(3);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      run(4000);
      sel[0] = 2'($urandom);
      rgb[0] = 24'($urandom);
    end
    run(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
